chroni_mem_arbiter: RTL and testbench

- Shares the single 2K x 8 synchronous video RAM port (11-bit address, 8-bit data) between two requesters:
  - the chroni display fetch engine, which reads text and font data;
  - the CPU bus, which reads and writes.
- Video fetch has fixed priority because it runs against hard scanline deadlines. The CPU uses the free slots.
- Read data is returned through a tagged pipeline, so each requester sees only its own data.

---
 rtl/chroni_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_chroni_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/chroni_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : chroni_mem_arbiter
// Purpose  : Shares one synchronous video RAM port between the chroni video
//            fetch engine (fixed priority) and the CPU bus. Read data goes
//            back through a tagged pipeline. Defining CHRONI_ARB_CPU_GUARD_EN
//            adds a run counter that caps how long video can starve the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module chroni_mem_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int RD_LAT      = 1,
    parameter int MAX_VID_RUN = 15
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2
    } grant_t;

    grant_t r_grant;
    grant_t w_grant_nxt;
    grant_t w_tag_in;
    grant_t r_tag [RD_LAT:1];
    logic   w_force_cpu;

`ifdef CHRONI_ARB_CPU_GUARD_EN
    localparam int c_CNT_W = $clog2(MAX_VID_RUN + 1);

    logic [c_CNT_W-1:0] r_run_cnt;

    assign w_force_cpu = cpu_req && (r_run_cnt == c_CNT_W'(MAX_VID_RUN));

    // Counts video grants that kept a pending CPU waiting; saturates at the cap
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_run_cnt <= '0;
        end else if (!cpu_req || (w_grant_nxt == GNT_CPU)) begin
            r_run_cnt <= '0;
        end else if ((w_grant_nxt == GNT_VID) && (r_run_cnt != c_CNT_W'(MAX_VID_RUN))) begin
            r_run_cnt <= r_run_cnt + c_CNT_W'(1);
        end
    end
`else
    // Guard absent: constant-false override, pure video priority
    assign w_force_cpu = (MAX_VID_RUN < 0);
`endif

    always_comb begin
        w_grant_nxt = GNT_NONE;
        if (w_force_cpu) begin
            w_grant_nxt = GNT_CPU;
        end else if (vid_req) begin
            w_grant_nxt = GNT_VID;
        end else if (cpu_req) begin
            w_grant_nxt = GNT_CPU;
        end
    end

    assign vid_ack = !reset && (w_grant_nxt == GNT_VID);
    assign cpu_ack = !reset && (w_grant_nxt == GNT_CPU);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_grant   <= GNT_NONE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            mem_we  <= 1'b0;
            case (w_grant_nxt)
                GNT_VID: mem_addr <= vid_addr;
                GNT_CPU: begin
                    mem_addr  <= cpu_addr;
                    mem_we    <= cpu_we;
                    mem_wdata <= cpu_wdata;
                end
                default: ;
            endcase
        end
    end

    // The grant register is the first tag stage; CPU writes carry no read tag
    always_comb begin
        w_tag_in = r_grant;
        if ((r_grant == GNT_CPU) && mem_we) begin
            w_tag_in = GNT_NONE;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag[i] <= GNT_NONE;
            end
            vid_valid  <= 1'b0;
            vid_data   <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            r_tag[1] <= w_tag_in;
            for (int i = 2; i <= RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            vid_valid  <= (r_tag[RD_LAT] == GNT_VID);
            cpu_rvalid <= (r_tag[RD_LAT] == GNT_CPU);
            if (r_tag[RD_LAT] == GNT_VID) begin
                vid_data <= mem_rdata;
            end
            if (r_tag[RD_LAT] == GNT_CPU) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chroni_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_chroni_mem_arbiter
// Purpose  : Directed plus randomized checking of chroni_mem_arbiter against
//            a transaction-level model (grant rule, shadow RAM, return queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chroni_mem_arbiter;

    localparam int MAXRUN = 15;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        vid_req, vid_ack, vid_valid;
    logic [10:0] vid_addr;
    logic [7:0]  vid_data;
    logic        cpu_req, cpu_we, cpu_ack, cpu_rvalid;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;

    always #5 vga_clk = ~vga_clk;

    chroni_mem_arbiter dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_data   (vid_data),
        .vid_valid  (vid_valid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // 2K x 8 synchronous RAM, 1-cycle read; unwritten words read as addr[7:0]
    logic [7:0] ram   [2048];
    bit         ram_w [2048];
    always @(posedge vga_clk) begin
        if (mem_we) begin
            ram[mem_addr]   <= mem_wdata;
            ram_w[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_w[mem_addr] ? ram[mem_addr] : mem_addr[7:0];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        int         kind;   // 1 = video, 2 = cpu
        logic [7:0] data;
    } ret_t;

    ret_t        rq [$];
    logic [7:0]  mmem   [2048];
    bit          mmem_w [2048];
    int          edges   = 0;
    int          run_len = 0;
    int          last_g  = 0;
    logic [10:0] e_addr  = '0;
    logic [7:0]  e_vdata = '0;
    logic [7:0]  e_cdata = '0;
    int          pct [3] = '{40, 75, 95};

    function automatic logic [7:0] m_rd(input logic [10:0] a);
        return mmem_w[a] ? mmem[a] : a[7:0];
    endfunction

    task automatic run_cycle(input bit vr, input logic [10:0] va, input bit cr,
                             input bit we, input logic [10:0] ca, input logic [7:0] wd);
        int   g;
        bit   force_cpu;
        bit   ev;
        bit   ec;
        ret_t r;
        @(negedge vga_clk);
        vid_req = vr; vid_addr = va;
        cpu_req = cr; cpu_we = we; cpu_addr = ca; cpu_wdata = wd;
        force_cpu = 1'b0;
`ifdef CHRONI_ARB_CPU_GUARD_EN
        force_cpu = cr && (run_len >= MAXRUN);
`endif
        g = force_cpu ? 2 : (vr ? 1 : (cr ? 2 : 0));
        #1;
        chk("vid_ack", 32'(vid_ack), 32'(g == 1));
        chk("cpu_ack", 32'(cpu_ack), 32'(g == 2));
        @(posedge vga_clk);
        #1;
        edges++;
        if (g == 1) e_addr = va;
        else if (g == 2) e_addr = ca;
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_we", 32'(mem_we), 32'(g == 2 && we));
        if (g == 2 && we) chk("mem_wdata", 32'(mem_wdata), 32'(wd));
        ev = 1'b0;
        ec = 1'b0;
        if (rq.size() > 0 && rq[0].due == edges) begin
            r = rq.pop_front();
            if (r.kind == 1) begin ev = 1'b1; e_vdata = r.data; end
            else begin ec = 1'b1; e_cdata = r.data; end
        end
        chk("vid_valid", 32'(vid_valid), 32'(ev));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ec));
        chk("vid_data", 32'(vid_data), 32'(e_vdata));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(e_cdata));
        if (g == 1) rq.push_back('{due: edges + 2, kind: 1, data: m_rd(va)});
        if (g == 2 && !we) rq.push_back('{due: edges + 2, kind: 2, data: m_rd(ca)});
        if (g == 2 && we) begin
            mmem[ca]   = wd;
            mmem_w[ca] = 1'b1;
        end
        if (!cr || g == 2) run_len = 0;
        else if (g == 1) run_len++;
        last_g = g;
    endtask

    task automatic idle();
        run_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".vid_ack"},    32'(vid_ack),    32'd0);
        chk({tag, ".cpu_ack"},    32'(cpu_ack),    32'd0);
        chk({tag, ".vid_valid"},  32'(vid_valid),  32'd0);
        chk({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        chk({tag, ".vid_data"},   32'(vid_data),   32'd0);
        chk({tag, ".cpu_rdata"},  32'(cpu_rdata),  32'd0);
        chk({tag, ".mem_addr"},   32'(mem_addr),   32'd0);
        chk({tag, ".mem_we"},     32'(mem_we),     32'd0);
        chk({tag, ".mem_wdata"},  32'(mem_wdata),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bit          cr;
        bit          cwe;
        logic [10:0] ca;
        logic [7:0]  cwd;
        cr = 1'b0; cwe = 1'b0; ca = '0; cwd = '0;

        reset = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #2;
        check_zero("por");
        @(negedge vga_clk);
        @(negedge vga_clk);
        reset = 1'b0;

        repeat (10) idle();

        for (int i = 0; i < 4; i++) run_cycle(1'b1, 11'(16 + i), 1'b0, 1'b0, '0, '0);
        repeat (3) idle();

        run_cycle(1'b0, '0, 1'b1, 1'b1, 11'h7FF, 8'hA5);
        idle();
        run_cycle(1'b0, '0, 1'b1, 1'b0, 11'h7FF, 8'h00);
        repeat (3) idle();

        for (int i = 0; i < 3; i++) run_cycle(1'b1, 11'(32 + i), 1'b1, 1'b0, 11'h7FF, 8'h00);
        run_cycle(1'b0, '0, 1'b1, 1'b0, 11'h7FF, 8'h00);
        repeat (3) idle();

        // Asynchronous reset while a video read is in flight
        run_cycle(1'b1, 11'h013, 1'b0, 1'b0, '0, '0);
        vid_req = 1'b0;
        @(posedge vga_clk);
        #2;
        vid_req = 1'b1;
        reset   = 1'b1;
        #1;
        check_zero("async_rst");
        rq.delete();
        e_addr = '0; e_vdata = '0; e_cdata = '0; run_len = 0; last_g = 0;
        @(negedge vga_clk);
        vid_req = 1'b0;
        @(negedge vga_clk);
        reset = 1'b0;
        repeat (4) idle();

        // Sustained video with a waiting CPU read
        for (int i = 0; i < 20; i++) run_cycle(1'b1, 11'(i), 1'b1, 1'b0, 11'h005, 8'h00);
        run_cycle(1'b0, '0, 1'b1, 1'b0, 11'h005, 8'h00);
        repeat (3) idle();

        for (int b = 0; b < 3; b++) begin
            for (int n = 0; n < 150; n++) begin
                if (cr && last_g == 2) cr = 1'b0;
                if (cr && $urandom_range(0, 9) == 0) begin
                    cr = 1'b0;
                end else if (!cr && $urandom_range(0, 1) == 1) begin
                    cr  = 1'b1;
                    cwe = 1'($urandom_range(0, 1));
                    ca  = 11'($urandom_range(0, 31));
                    cwd = 8'($urandom);
                end
                run_cycle(($urandom_range(0, 99) < pct[b]), 11'($urandom_range(0, 31)),
                          cr, cwe, ca, cwd);
            end
        end
        repeat (4) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
